// File: rtl/resp_checker.sv
// Response checker for 2-in/2-out combinational blocks: accepts one {a,b} vector at a time,
// samples {x,y} SETTLE cycles later against EXP_TABLE, and reports error count, first failing index and pass.
module resp_checker #(
    parameter logic [7:0] EXP_TABLE = 8'b11_10_01_00,
    parameter int         N_VECTORS = 4,
    parameter int         SETTLE    = 2,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    output logic             ready,
    input  logic             a,
    input  logic             b,
    input  logic             x,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_idx
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VEC,
        SETTLE_ST,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [7:0]       N_VEC     = 8'(N_VECTORS);
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [7:0]       vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;

    logic [1:0] exp_xy;
    logic       mismatch;
    logic [7:0] vec_inc;

    assign exp_xy   = EXP_TABLE[{idx_q, 1'b0} +: 2];
    assign mismatch = ({x, y} != exp_xy);
    assign vec_inc  = vec_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            err_q    <= '0;
            first_q  <= CNT_MAX;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        err_d    = err_q;
        first_d  = first_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT_VEC;
                    vec_d   = '0;
                    err_d   = '0;
                    first_d = CNT_MAX;
                end
            end
            WAIT_VEC: begin
                if (valid) begin
                    idx_d    = {a, b};
                    settle_d = SETTLE_LD;
                    state_d  = SETTLE_ST;
                end
            end
            SETTLE_ST: begin
                // Counter value 1 marks the edge that lies exactly SETTLE cycles after accept.
                if (settle_q <= 4'd1) begin
                    settle_d = '0;
                    if (mismatch) begin
                        if (err_q == '0) begin
                            first_d = CNT_W'(vec_q);
                        end
                        if (err_q != CNT_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                    vec_d   = vec_inc;
                    state_d = (vec_inc == N_VEC) ? DONE : WAIT_VEC;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready     = (state_q == WAIT_VEC);
    assign busy      = (state_q == WAIT_VEC) || (state_q == SETTLE_ST);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == '0);
    assign err_count = err_q;
    assign first_idx = first_q;

endmodule

// File: tb/tb_resp_checker.sv
// Scoreboard bench for resp_checker: a default instance plus a CNT_W=2/N_VECTORS=6 instance for saturation.
module tb_resp_checker;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst;
    logic start1, start2, valid, a, b, x, y;
    logic       ready1, busy1, done1, pass1;
    logic [7:0] err1, first1;
    logic       ready2, busy2, done2, pass2;
    logic [1:0] err2, first2;

    resp_checker dut (
        .clk(clk), .rst(rst), .start(start1), .valid(valid), .ready(ready1),
        .a(a), .b(b), .x(x), .y(y), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_idx(first1)
    );

    resp_checker #(.N_VECTORS(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .valid(valid), .ready(ready2),
        .a(a), .b(b), .x(x), .y(y), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_idx(first2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation mux: sel picks which instance the tasks talk to.
    logic       sel;
    logic       m_ready, m_busy, m_done, m_pass;
    logic [7:0] m_err, m_first;
    always_comb begin
        m_ready = sel ? ready2 : ready1;
        m_busy  = sel ? busy2  : busy1;
        m_done  = sel ? done2  : done1;
        m_pass  = sel ? pass2  : pass1;
        m_err   = sel ? {6'd0, err2}   : err1;
        m_first = sel ? {6'd0, first2} : first1;
    end

    typedef struct {
        logic [7:0] err;
        logic [7:0] first;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tbl = 8'b11_10_01_00;
    logic [7:0] err_m, first_m, cmax;
    int vidx, last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        cmax = sel ? 8'd3 : 8'd255;
        err_m = 8'd0; first_m = cmax; vidx = 0;
        check("busy_after_start", m_busy, 1);
        check("done_after_start", m_done, 0);
        check("err_after_start", m_err, 0);
    endtask

    task automatic send_vec(input logic [1:0] ab, input logic [1:0] xy_mid,
                            input logic [1:0] xy_smp, input logic chk_gap);
        int k;
        exp_t e;
        logic [1:0] ex;
        k = 0;
        while (!m_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!m_ready) begin
            check("ready_wait", 0, 1);
            return;
        end
        valid = 1'b1; {a, b} = ab; {x, y} = xy_mid;
        @(posedge clk); #1;
        valid = 1'b0;
        if (chk_gap) check("accept_gap", cyc - last_acc, SETTLE + 1);
        last_acc = cyc;
        ex = tbl[ab*2 +: 2];
        if (xy_smp != ex) begin
            if (err_m == 8'd0) first_m = 8'(vidx) & cmax;
            if (err_m < cmax) err_m++;
        end
        vidx++;
        e.err = err_m; e.first = first_m;
        sb.push_back(e);
        repeat (SETTLE - 1) begin
            check("ready_in_settle", m_ready, 0);
            @(posedge clk); #1;
        end
        {x, y} = xy_smp;
        @(posedge clk); #1;
        {x, y} = ~xy_smp;
        e = sb.pop_front();
        check("err_count", m_err, e.err);
        check("first_idx", m_first, e.first);
        $display("vec %0d ab=%b xy=%b err_count=%0d first_idx=%0d", vidx - 1, ab, xy_smp, m_err, m_first);
    endtask

    task automatic end_check(input logic pass_exp);
        check("done", m_done, 1);
        check("busy_end", m_busy, 0);
        check("pass", m_pass, pass_exp);
        check("final_err", m_err, err_m);
        check("final_first", m_first, first_m);
    endtask

    initial begin
        int acc, prev;
        logic r;
        logic [1:0] lv;
        rst = 1'b1; start1 = 0; start2 = 0; valid = 0; a = 0; b = 0; x = 0; y = 0;
        sel = 1'b0; last_acc = 0;
        #1;
        check("rst_ready", ready1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_err", err1, 0);
        check("rst_first", first1, 8'hFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // All-correct run
        do_start();
        for (int i = 0; i < 4; i++) begin
            lv = 2'(i);
            send_vec(lv, tbl[i*2 +: 2], tbl[i*2 +: 2], i != 0);
        end
        end_check(1'b1);
        valid = 1'b1; @(posedge clk); #1; valid = 1'b0;
        check("valid_in_done_done", done1, 1);
        check("valid_in_done_err", err1, 0);

        // Vectors 2 and 3 wrong
        do_start();
        for (int i = 0; i < 4; i++) begin
            lv = 2'(i);
            send_vec(lv, tbl[i*2 +: 2], (i >= 2) ? 2'b00 : tbl[i*2 +: 2], i != 0);
        end
        end_check(1'b0);

        // Glitch during settle only, then wrong only on the sample edge
        do_start();
        send_vec(2'b01, 2'b10, 2'b01, 1'b0);
        send_vec(2'b10, 2'b10, 2'b00, 1'b1);
        send_vec(2'b11, 2'b11, 2'b11, 1'b1);
        send_vec(2'b00, 2'b00, 2'b00, 1'b1);
        end_check(1'b0);

        // valid held high for the whole run
        do_start();
        valid = 1'b1; {a, b} = 2'b11; {x, y} = 2'b11;
        acc = 0; prev = 0;
        for (int i = 0; i < 15; i++) begin
            r = ready1;
            @(posedge clk); #1;
            if (r) begin
                if (acc > 0) check("hold_gap", cyc - prev, SETTLE + 1);
                prev = cyc; acc++;
            end
        end
        valid = 1'b0;
        check("hold_accepts", acc, 4);
        end_check(1'b1);
        $display("hold-valid run accepts=%0d", acc);

        // Async reset during settle of vector 1
        do_start();
        send_vec(2'b00, 2'b00, 2'b11, 1'b0);
        valid = 1'b1; {a, b} = 2'b01;
        @(posedge clk); #1;
        valid = 1'b0;
        check("busy_pre_rst", busy1, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", ready1, 0);
        check("arst_busy", busy1, 0);
        check("arst_done", done1, 0);
        check("arst_pass", pass1, 0);
        check("arst_err", err1, 0);
        check("arst_first", first1, 8'hFF);
        $display("async reset applied mid-settle");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", busy1, 0);
        do_start();
        for (int i = 0; i < 4; i++) begin
            lv = 2'(i);
            send_vec(lv, tbl[i*2 +: 2], tbl[i*2 +: 2], i != 0);
        end
        end_check(1'b1);

        // Saturation with CNT_W=2, 6 vectors, all wrong
        sel = 1'b1;
        do_start();
        for (int i = 0; i < 6; i++) begin
            lv = 2'(i % 4);
            send_vec(lv, tbl[(i % 4)*2 +: 2], ~tbl[(i % 4)*2 +: 2], i != 0);
        end
        end_check(1'b0);
        check("sat_err_value", err2, 3);
        check("sat_first_value", first2, 0);
        do_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
